sfx_sequencer: RTL and testbench

Parametrised sound-effect sequencer for the snake game, replacing the fixed three-note sound generator.
- Plays one of two stored note sequences: FOOD on a food_eaten edge, OVER on a game_over edge.
- Note count, note length and inter-note gap are configurable; game-over pre-empts food.
- Drives the board speaker pin directly, with a mute enable and busy/done status for game control.

---
 rtl/sfx_pkg.sv | 25 ++
 rtl/sfx_tone.sv | 29 ++
 rtl/sfx_sequencer.sv | 114 +++++++++++
 tb/tb_sfx_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// sfx_pkg: effect/state types, note tables and tone half-period helpers for sfx_sequencer
package sfx_pkg;

    typedef enum logic {SFX_FOOD, SFX_OVER} sfx_t;
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam int MAX_NOTES = 8;
    localparam int FOOD_NOTES [MAX_NOTES] = '{1047, 1319, 1568, 2093, 0, 0, 0, 0};
    localparam int OVER_NOTES [MAX_NOTES] = '{784, 659, 523, 392, 0, 0, 0, 0};

    function automatic int half_period(int fclk, int freq);
        return freq == 0 ? 0 : fclk / (2 * freq);
    endfunction

    function automatic int max_half_period(int fclk);
        int m;
        m = 0;
        for (int i = 0; i < MAX_NOTES; i++) begin
            if (half_period(fclk, FOOD_NOTES[i]) > m) m = half_period(fclk, FOOD_NOTES[i]);
            if (half_period(fclk, OVER_NOTES[i]) > m) m = half_period(fclk, OVER_NOTES[i]);
        end
        return m;
    endfunction

endpackage

// File: rtl/sfx_tone.sv
// sfx_tone: square-wave generator toggling every half_period cycles; restart or half_period=0 holds it low
module sfx_tone #(
    parameter int HPW = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           restart,
    input  logic [HPW-1:0] half_period,
    output logic           spkr
);

    logic [HPW-1:0] phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
            spkr  <= 1'b0;
        end else if (restart || half_period == '0) begin
            phase <= '0;
            spkr  <= 1'b0;
        end else if (phase == half_period - HPW'(1)) begin
            phase <= '0;
            spkr  <= ~spkr;
        end else begin
            phase <= phase + HPW'(1);
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays FOOD/OVER note sequences on input edges; game_over pre-empts food
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int FCLK     = 50_000_000,
    parameter int N_NOTES  = 4,
    parameter int NOTE_CYC = FCLK / 10,
    parameter int GAP_CYC  = FCLK / 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic food_eaten,
    input  logic game_over,
    input  logic enable,
    output logic spkr,
    output logic busy,
    output logic sfx_done
);

    localparam int HPW = $clog2(max_half_period(FCLK) + 1);
    localparam int DW  = $clog2((NOTE_CYC > GAP_CYC ? NOTE_CYC : GAP_CYC) + 1);
    localparam int IW  = $clog2(MAX_NOTES);

    state_t          state, state_d;
    sfx_t            eff, eff_d;
    logic [IW-1:0]   note_idx, idx_d;
    logic [DW-1:0]   dur_cnt, dur_d;
    logic            food_q, over_q, armed;
    logic            food_trig, over_trig, food_ok, start, done_d, restart, tone;
    logic [HPW-1:0]  food_hp [MAX_NOTES];
    logic [HPW-1:0]  over_hp [MAX_NOTES];
    logic [HPW-1:0]  hp;

    for (genvar i = 0; i < MAX_NOTES; i++) begin : g_hp
        assign food_hp[i] = HPW'(half_period(FCLK, FOOD_NOTES[i]));
        assign over_hp[i] = HPW'(half_period(FCLK, OVER_NOTES[i]));
    end

    // armed masks the first cycle after reset so a level held through release is not an edge
    assign over_trig = armed & game_over & ~over_q;
    assign food_trig = armed & food_eaten & ~food_q;
    assign food_ok   = food_trig & (state == IDLE || eff == SFX_FOOD);

    always_comb begin
        state_d = state;
        eff_d   = eff;
        idx_d   = note_idx;
        dur_d   = dur_cnt + DW'(1);
        start   = 1'b0;
        done_d  = 1'b0;
        if (over_trig || food_ok) begin
            state_d = PLAY;
            eff_d   = over_trig ? SFX_OVER : SFX_FOOD;
            idx_d   = '0;
            dur_d   = '0;
            start   = 1'b1;
        end else if (state == IDLE) begin
            dur_d = '0;
        end else if (state == PLAY && dur_cnt == DW'(NOTE_CYC - 1)) begin
            dur_d = '0;
            if (note_idx == IW'(N_NOTES - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (GAP_CYC == 0) begin
                idx_d = note_idx + IW'(1);
                start = 1'b1;
            end else begin
                state_d = GAP;
            end
        end else if (state == GAP && dur_cnt == DW'(GAP_CYC - 1)) begin
            state_d = PLAY;
            idx_d   = note_idx + IW'(1);
            dur_d   = '0;
            start   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            eff      <= SFX_FOOD;
            note_idx <= '0;
            dur_cnt  <= '0;
            food_q   <= 1'b0;
            over_q   <= 1'b0;
            armed    <= 1'b0;
            sfx_done <= 1'b0;
        end else begin
            state    <= state_d;
            eff      <= eff_d;
            note_idx <= idx_d;
            dur_cnt  <= dur_d;
            food_q   <= food_eaten;
            over_q   <= game_over;
            armed    <= 1'b1;
            sfx_done <= done_d;
        end
    end

    assign restart = start | (state_d != PLAY);
    assign hp      = eff == SFX_OVER ? over_hp[note_idx] : food_hp[note_idx];

    sfx_tone #(.HPW(HPW)) u_tone (
        .clk         (clk),
        .reset_n     (reset_n),
        .restart     (restart),
        .half_period (hp),
        .spkr        (tone)
    );

    assign spkr = tone & enable;
    assign busy = state != IDLE;

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: directed checks of sfx_sequencer timing, pre-emption, gating and reset
module tb_sfx_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic food_eaten = 1'b0;
    logic game_over = 1'b0;
    logic enable = 1'b1;
    logic spkr, busy, sfx_done;
    logic spkr1, busy1, done1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    sfx_sequencer #(.FCLK(200_000), .N_NOTES(4), .NOTE_CYC(200), .GAP_CYC(20)) u_dut (
        .clk(clk), .reset_n(reset_n), .food_eaten(food_eaten), .game_over(game_over),
        .enable(enable), .spkr(spkr), .busy(busy), .sfx_done(sfx_done)
    );

    sfx_sequencer #(.FCLK(200_000), .N_NOTES(4), .NOTE_CYC(200), .GAP_CYC(0)) u_gap0 (
        .clk(clk), .reset_n(reset_n), .food_eaten(food_eaten), .game_over(game_over),
        .enable(enable), .spkr(spkr1), .busy(busy1), .sfx_done(done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv(input int to);
        while (cyc < to) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step();
        food_eaten = 1'b0;
        game_over = 1'b0;
        enable = 1'b1;
        step();
        reset_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic fire_food();
        food_eaten = 1'b1;
        step();
        food_eaten = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++; if (spkr !== 1'b0) begin bad++; $display("FAIL reset_spkr: got %b want 0", spkr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (sfx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", sfx_done); end
        reset_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_food();
        fire_food();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL food_busy_rise: got %b want 1", busy); end
        total++; if (spkr !== 1'b0) begin bad++; $display("FAIL food_spkr_start: got %b want 0", spkr); end
        adv(94);
        total++; if (spkr !== 1'b0) begin bad++; $display("FAIL food_spkr_94: got %b want 0", spkr); end
        adv(95);
        total++; if (spkr !== 1'b1) begin bad++; $display("FAIL food_spkr_95: got %b want 1", spkr); end
        adv(190);
        total++; if (spkr !== 1'b0) begin bad++; $display("FAIL food_spkr_190: got %b want 0", spkr); end
        adv(210);
        total++; if (busy !== 1'b1 || spkr !== 1'b0) begin bad++; $display("FAIL food_gap: got busy=%b spkr=%b want 1 0", busy, spkr); end
        adv(294);
        total++; if (spkr !== 1'b0) begin bad++; $display("FAIL food_n1_294: got %b want 0", spkr); end
        adv(295);
        total++; if (spkr !== 1'b1) begin bad++; $display("FAIL food_n1_295: got %b want 1", spkr); end
        while (sfx_done !== 1'b1 && cyc < 2000) step();
        total++; if (cyc != 860) begin bad++; $display("FAIL food_done_time: got %0d want 860", cyc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL food_done_busy: got %b want 0", busy); end
        step();
        total++; if (sfx_done !== 1'b0) begin bad++; $display("FAIL food_done_pulse: got %b want 0", sfx_done); end
    endtask

    task automatic test_preempt();
        fire_food();
        adv(300);
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        total++; if (busy !== 1'b1 || spkr !== 1'b0) begin bad++; $display("FAIL pre_restart: got busy=%b spkr=%b want 1 0", busy, spkr); end
        adv(427);
        total++; if (spkr !== 1'b0) begin bad++; $display("FAIL pre_over_427: got %b want 0", spkr); end
        adv(428);
        total++; if (spkr !== 1'b1) begin bad++; $display("FAIL pre_over_428: got %b want 1", spkr); end
        adv(600);
        food_eaten = 1'b1;
        step();
        food_eaten = 1'b0;
        adv(671);
        total++; if (spkr !== 1'b0) begin bad++; $display("FAIL pre_ignore_671: got %b want 0", spkr); end
        adv(672);
        total++; if (spkr !== 1'b1) begin bad++; $display("FAIL pre_ignore_672: got %b want 1", spkr); end
        while (sfx_done !== 1'b1 && cyc < 2000) step();
        total++; if (cyc != 1161) begin bad++; $display("FAIL pre_done_time: got %0d want 1161", cyc); end
        step();
    endtask

    task automatic test_both();
        food_eaten = 1'b1;
        game_over = 1'b1;
        step();
        food_eaten = 1'b0;
        game_over = 1'b0;
        cyc = 0;
        adv(95);
        total++; if (spkr !== 1'b0) begin bad++; $display("FAIL both_95: got %b want 0", spkr); end
        adv(126);
        total++; if (spkr !== 1'b0) begin bad++; $display("FAIL both_126: got %b want 0", spkr); end
        adv(127);
        total++; if (spkr !== 1'b1) begin bad++; $display("FAIL both_127: got %b want 1", spkr); end
        while (sfx_done !== 1'b1 && cyc < 2000) step();
        total++; if (cyc != 860) begin bad++; $display("FAIL both_done_time: got %0d want 860", cyc); end
        step();
    endtask

    task automatic test_held_reset();
        reset_n = 1'b0;
        food_eaten = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (10) step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_no_trigger: got %b want 0", busy); end
        food_eaten = 1'b0;
        step();
        food_eaten = 1'b1;
        step();
        food_eaten = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_retrigger: got %b want 1", busy); end
        do_reset();
    endtask

    task automatic test_enable();
        int loud;
        loud = 0;
        enable = 1'b0;
        fire_food();
        while (sfx_done !== 1'b1 && cyc < 2000) begin
            if (spkr !== 1'b0) loud++;
            step();
        end
        total++; if (loud != 0) begin bad++; $display("FAIL en_spkr_quiet: got %0d loud cycles want 0", loud); end
        total++; if (cyc != 860 || busy !== 1'b0) begin bad++; $display("FAIL en_done: got cyc=%0d busy=%b want 860 0", cyc, busy); end
        enable = 1'b1;
        step();
    endtask

    task automatic test_gap0();
        fire_food();
        while (done1 !== 1'b1 && cyc < 2000) step();
        total++; if (cyc != 800) begin bad++; $display("FAIL gap0_done_time: got %0d want 800", cyc); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL gap0_busy: got %b want 0", busy1); end
        do_reset();
    endtask

    task automatic test_async_reset();
        int noisy;
        noisy = 0;
        fire_food();
        adv(100);
        total++; if (spkr !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL ar_pre: got spkr=%b busy=%b want 1 1", spkr, busy); end
        #3 reset_n = 1'b0;
        #1;
        total++; if (spkr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ar_async: got spkr=%b busy=%b want 0 0", spkr, busy); end
        #2 reset_n = 1'b1;
        repeat (30) begin
            step();
            if (spkr !== 1'b0 || busy !== 1'b0 || sfx_done !== 1'b0) noisy++;
        end
        total++; if (noisy != 0) begin bad++; $display("FAIL ar_idle: got %0d active cycles want 0", noisy); end
    endtask

    initial begin
        test_reset();
        test_food();
        test_preempt();
        test_both();
        test_held_reset();
        test_enable();
        test_gap0();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
